fma_result_writeback: RTL and testbench
=======================================

// Module: fma_result_writeback
// PURPOSE
//  Downstream of the 128-lane FMA array controllers (RoPE / post-attn-norm / norm1 result buffers).
//  Captures one full-width result vector per valid pulse into a 2-entry ping-pong buffer.
//  Slices each vector into SRAM-width beats and drives them to the SRAM write port over valid/ready,
//  with an incrementing address per beat. Lets the FMA controllers start the next job while the previous drains.
// PARAMETERS
//  BW_FP      17   bits per FP element
//  N_ELEM     128  elements per result vector (VALUE_MN*2)
//  BEAT_ELEMS 16   elements per SRAM beat; N_ELEM % BEAT_ELEMS == 0; N_BEATS = N_ELEM/BEAT_ELEMS (8)
//  ADDR_W     12   SRAM word-address width
// PORTS
//  clk          in   1                   clock
//  rst_n        in   1                   async active-low reset
//  res_valid    in   1                   pulse: res_data/res_addr valid this cycle
//  res_data     in   N_ELEM*BW_FP        result vector, element i at [BW_FP*i +: BW_FP]
//  res_addr     in   ADDR_W              SRAM base address for beat 0 of this vector
//  res_ready    out  1                   at least one buffer slot free
//  wr_valid     out  1                   beat presented to SRAM
//  wr_ready     in   1                   SRAM accepts beat when wr_valid&&wr_ready
//  wr_data      out  BEAT_ELEMS*BW_FP    beat payload
//  wr_addr      out  ADDR_W              beat address
//  wr_last      out  1                   final beat of a vector
//  vec_done     out  1                   1-cycle pulse, cycle after last beat handshake
//  busy         out  1                   any slot occupied
//  overflow_err out  1                   sticky: res_valid seen while res_ready==0
// BEHAVIOUR
//  Reset (async): both slots empty, wr_ptr=rd_ptr=0, beat_cnt=0; outputs: res_ready=1, wr_valid=0,
//   wr_data=0, wr_addr=0, wr_last=0, vec_done=0, busy=0, overflow_err=0.
//  Capture: res_valid&&res_ready -> store data+addr into slot[wr_ptr], mark full, toggle wr_ptr.
//   res_valid&&!res_ready -> input dropped, overflow_err<=1 (cleared only by reset).
//  res_ready = !(slot0_full && slot1_full), registered state, no comb path from res_valid.
//  FSM: IDLE -> SEND when slot[rd_ptr] full (earliest one cycle after capture; first wr_valid
//   at capture+1). SEND: wr_valid=1, wr_data=slot[rd_ptr] elements [beat_cnt*BEAT_ELEMS +: BEAT_ELEMS],
//   wr_addr=base+beat_cnt mod 2^ADDR_W (wraps silently), wr_last=(beat_cnt==N_BEATS-1).
//  wr_valid&&!wr_ready: data/addr/last held stable; wr_valid never drops without handshake.
//  Handshake, not last: beat_cnt++. Handshake on last: beat_cnt<=0, slot freed, rd_ptr toggled,
//   vec_done pulse next cycle; if other slot full stay in SEND (back-to-back, no bubble), else IDLE.
//  Simultaneous capture and last-beat handshake with both slots full: freeing happens the same
//   edge, but res_ready was 0 that cycle so the input is dropped (overflow_err set).
//  Capture into the slot being drained never occurs (slot full => not writable).
//  Order strictly FIFO; all output regs except vec_done/overflow_err are combinational views of
//   state (rd slot, beat_cnt), so wr_* change only on clk edges.
//  busy = slot0_full | slot1_full. Reset mid-drain: aborts, no further beats, all state cleared.
// TESTING
//  1. One vector, data elem i = i, base=0x100, wr_ready=1 -> 8 beats addr 0x100..0x107, beat k elems
//     16k..16k+15, wr_last on beat 7, vec_done 1 cycle later, busy falls.
//  2. wr_ready toggling 1/0 each cycle -> 8 beats in 16 cycles, payload/addr stable during stalls.
//  3. Two vectors 1 cycle apart (bases 0x000, 0x200), wr_ready=1 -> 16 consecutive beats, no
//     bubble, second starts at 0x200; res_ready=1 throughout.
//  4. Three vectors while wr_ready=0 -> third dropped, overflow_err=1, res_ready=0; release ready
//     -> first two drain intact.
//  5. base=0xFFE (ADDR_W=12) -> addrs 0xFFE,0xFFF,0x000..0x005.
//  6. Assert rst_n low after beat 3 -> wr_valid=0 immediately, all outputs at reset values; a new
//     vector afterwards drains from beat 0.

Source files
------------

// File: rtl/fma_result_writeback.sv
// Result writeback for the FMA array: captures full result vectors into a 2-entry ping-pong
// buffer and drains each one to the SRAM write port as address-incrementing beats.
module fma_result_writeback #(
    parameter int BW_FP      = 17,
    parameter int N_ELEM     = 128,
    parameter int BEAT_ELEMS = 16,
    parameter int ADDR_W     = 12
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         res_valid,
    input  logic [N_ELEM*BW_FP-1:0]      res_data,
    input  logic [ADDR_W-1:0]            res_addr,
    output logic                         res_ready,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [BEAT_ELEMS*BW_FP-1:0]  wr_data,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         wr_last,
    output logic                         vec_done,
    output logic                         busy,
    output logic                         overflow_err
);

    localparam int N_BEATS = N_ELEM / BEAT_ELEMS;
    localparam int VEC_W   = N_ELEM * BW_FP;
    localparam int BEAT_W  = BEAT_ELEMS * BW_FP;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [VEC_W-1:0]  slot_data [2];
    logic [ADDR_W-1:0] slot_addr [2];
    logic [1:0]        slot_full;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [CNT_W-1:0]  beat_cnt;
    logic              capture;
    logic              drop;
    logic              sending;
    logic              at_last;
    logic              handshake;
    logic              last_hs;

    assign res_ready = ~(slot_full[0] & slot_full[1]);
    assign capture   = res_valid & res_ready;
    assign drop      = res_valid & ~res_ready;
    assign sending   = (state == SEND);
    assign at_last   = (beat_cnt == LAST_BEAT);
    assign handshake = sending & wr_ready;
    assign last_hs   = handshake & at_last;
    assign busy      = |slot_full;

    // Payload storage needs no reset; the full flags alone decide whether a slot is meaningful.
    always_ff @(posedge clk) begin
        if (capture) begin
            slot_data[wr_ptr] <= res_data;
            slot_addr[wr_ptr] <= res_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot_full    <= 2'b00;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            beat_cnt     <= '0;
            vec_done     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            state    <= state_next;
            vec_done <= last_hs;
            if (drop) begin
                overflow_err <= 1'b1;
            end
            // A capture never targets the slot being freed: that would need both slots full.
            if (capture) begin
                slot_full[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
            end
            if (last_hs) begin
                slot_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
                beat_cnt          <= '0;
            end else if (handshake) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    // Capture is folded into the transitions so a fresh vector starts a cycle earlier, with no bubble.
    always_comb begin
        state_next = state;
        wr_valid   = 1'b0;
        wr_data    = '0;
        wr_addr    = '0;
        wr_last    = 1'b0;
        case (state)
            IDLE: begin
                if (slot_full[rd_ptr] || capture) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                wr_valid = 1'b1;
                wr_data  = slot_data[rd_ptr][beat_cnt*BEAT_W +: BEAT_W];
                wr_addr  = slot_addr[rd_ptr] + ADDR_W'(beat_cnt);
                wr_last  = at_last;
                if (last_hs && !(slot_full[~rd_ptr] || capture)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fma_result_writeback.sv
// Directed self-checking bench for fma_result_writeback: single, stalled, back-to-back,
// overflow, address-wrap and mid-drain-reset scenarios.
module tb_fma_result_writeback;

    localparam int BW_FP      = 17;
    localparam int N_ELEM     = 128;
    localparam int BEAT_ELEMS = 16;
    localparam int ADDR_W     = 12;
    localparam int N_BEATS    = 8;
    localparam int VEC_W      = N_ELEM * BW_FP;
    localparam int BEAT_W     = BEAT_ELEMS * BW_FP;

    logic              clk;
    logic              rst_n;
    logic              res_valid;
    logic [VEC_W-1:0]  res_data;
    logic [ADDR_W-1:0] res_addr;
    logic              res_ready;
    logic              wr_valid;
    logic              wr_ready;
    logic [BEAT_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_last;
    logic              vec_done;
    logic              busy;
    logic              overflow_err;

    int checks = 0;
    int errors = 0;

    fma_result_writeback #(
        .BW_FP(BW_FP), .N_ELEM(N_ELEM), .BEAT_ELEMS(BEAT_ELEMS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_data(res_data), .res_addr(res_addr), .res_ready(res_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr),
        .wr_last(wr_last), .vec_done(vec_done), .busy(busy), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [BEAT_W-1:0] observed,
                                input logic [BEAT_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Element i of the vector is seed + i*step, truncated to the element width.
    function automatic logic [VEC_W-1:0] make_vec(input int seed, input int step);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            v[i*BW_FP +: BW_FP] = BW_FP'(seed + i * step);
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [VEC_W-1:0] vec, input logic [ADDR_W-1:0] base);
        res_valid = 1'b1;
        res_data  = vec;
        res_addr  = base;
        tick();
        res_valid = 1'b0;
    endtask

    // Accept n_beats beats, checking every presented beat against the model; span is the
    // number of cycles from the first presented beat to the final accepted one.
    task automatic drain_vec(input logic [VEC_W-1:0] vec, input logic [ADDR_W-1:0] base,
                             input int n_beats, input bit toggle, output int span);
        int beat;
        int cyc;
        int first;
        bit ph;
        logic [ADDR_W-1:0] exp_addr;
        beat  = 0;
        cyc   = 0;
        first = -1;
        ph    = 1'b0;
        span  = 0;
        while (beat < n_beats && cyc < 100) begin
            if (toggle) begin
                if (wr_valid) begin
                    wr_ready = ph;
                    ph = ~ph;
                end else begin
                    wr_ready = 1'b0;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (wr_valid) begin
                if (first < 0) first = cyc;
                exp_addr = base + ADDR_W'(beat);
                check_output("beat_data", wr_data, vec[beat*BEAT_W +: BEAT_W]);
                check_output("beat_addr", wr_addr, exp_addr);
                check_output("beat_last", wr_last, (beat == N_BEATS - 1));
                if (wr_ready) begin
                    if (beat == n_beats - 1) span = cyc - first + 1;
                    beat++;
                end
            end
            tick();
            res_valid = 1'b0;
            cyc++;
        end
        check_output("drain_complete", beat, n_beats);
    endtask

    initial begin
        logic [VEC_W-1:0] va;
        logic [VEC_W-1:0] vb;
        logic [VEC_W-1:0] vc;
        int span;

        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_addr  = '0;
        wr_ready  = 1'b0;
        tick();
        tick();
        check_output("rst_res_ready", res_ready, 1'b1);
        check_output("rst_wr_valid", wr_valid, 1'b0);
        check_output("rst_wr_data", wr_data, '0);
        check_output("rst_wr_addr", wr_addr, '0);
        check_output("rst_wr_last", wr_last, 1'b0);
        check_output("rst_vec_done", vec_done, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_overflow", overflow_err, 1'b0);
        rst_n = 1'b1;
        tick();

        $display("[TB] single vector, base 0x100");
        va = make_vec(0, 1);
        wr_ready = 1'b1;
        apply_stimulus(va, 12'h100);
        check_output("t1_busy", busy, 1'b1);
        drain_vec(va, 12'h100, N_BEATS, 1'b0, span);
        check_output("t1_vec_done", vec_done, 1'b1);
        check_output("t1_busy_fall", busy, 1'b0);
        check_output("t1_idle", wr_valid, 1'b0);
        tick();
        check_output("t1_done_pulse", vec_done, 1'b0);

        $display("[TB] wr_ready toggling");
        va = make_vec('h1000, 3);
        apply_stimulus(va, 12'h040);
        drain_vec(va, 12'h040, N_BEATS, 1'b1, span);
        check_output("t2_span", span, 16);
        check_output("t2_vec_done", vec_done, 1'b1);
        tick();

        $display("[TB] two vectors back to back");
        va = make_vec('h0a5a, 5);
        vb = make_vec('h1f00, 7);
        wr_ready = 1'b1;
        apply_stimulus(va, 12'h000);
        check_output("t3_res_ready_b", res_ready, 1'b1);
        res_valid = 1'b1;
        res_data  = vb;
        res_addr  = 12'h200;
        drain_vec(va, 12'h000, N_BEATS, 1'b0, span);
        check_output("t3_span_a", span, 8);
        check_output("t3_res_ready_mid", res_ready, 1'b1);
        check_output("t3_no_bubble", wr_valid, 1'b1);
        check_output("t3_vec_done_a", vec_done, 1'b1);
        drain_vec(vb, 12'h200, N_BEATS, 1'b0, span);
        check_output("t3_span_b", span, 8);
        check_output("t3_vec_done_b", vec_done, 1'b1);
        tick();
        check_output("t3_busy_end", busy, 1'b0);

        $display("[TB] overflow with SRAM stalled");
        va = make_vec('h0100, 1);
        vb = make_vec('h0300, 2);
        vc = make_vec('h1234, 9);
        wr_ready = 1'b0;
        apply_stimulus(va, 12'h300);
        check_output("t4_res_ready_1", res_ready, 1'b1);
        apply_stimulus(vb, 12'h400);
        check_output("t4_res_ready_0", res_ready, 1'b0);
        check_output("t4_no_overflow", overflow_err, 1'b0);
        apply_stimulus(vc, 12'h500);
        check_output("t4_overflow", overflow_err, 1'b1);
        check_output("t4_res_ready_still0", res_ready, 1'b0);
        check_output("t4_held_valid", wr_valid, 1'b1);
        check_output("t4_held_addr", wr_addr, 12'h300);
        check_output("t4_held_data", wr_data, va[BEAT_W-1:0]);
        drain_vec(va, 12'h300, N_BEATS, 1'b0, span);
        check_output("t4_second_ready", wr_valid, 1'b1);
        drain_vec(vb, 12'h400, N_BEATS, 1'b0, span);
        tick();
        tick();
        check_output("t4_third_dropped", wr_valid, 1'b0);
        check_output("t4_busy_end", busy, 1'b0);
        check_output("t4_overflow_sticky", overflow_err, 1'b1);

        $display("[TB] address wrap at 0xFFE");
        va = make_vec('h1ff00, 11);
        apply_stimulus(va, 12'hffe);
        drain_vec(va, 12'hffe, N_BEATS, 1'b0, span);
        check_output("t5_vec_done", vec_done, 1'b1);
        tick();

        $display("[TB] reset mid-drain");
        va = make_vec('h0777, 13);
        apply_stimulus(va, 12'h600);
        drain_vec(va, 12'h600, 4, 1'b0, span);
        check_output("t6_pre_valid", wr_valid, 1'b1);
        check_output("t6_pre_addr", wr_addr, 12'h604);
        rst_n = 1'b0;
        #1;
        check_output("t6_wr_valid", wr_valid, 1'b0);
        check_output("t6_wr_data", wr_data, '0);
        check_output("t6_wr_addr", wr_addr, '0);
        check_output("t6_wr_last", wr_last, 1'b0);
        check_output("t6_busy", busy, 1'b0);
        check_output("t6_res_ready", res_ready, 1'b1);
        check_output("t6_vec_done", vec_done, 1'b0);
        check_output("t6_overflow", overflow_err, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_output("t6_no_resume", wr_valid, 1'b0);
        vb = make_vec('h0055, 17);
        apply_stimulus(vb, 12'h700);
        drain_vec(vb, 12'h700, N_BEATS, 1'b0, span);
        check_output("t6_vec_done_new", vec_done, 1'b1);
        tick();
        check_output("t6_busy_end", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
